// File: rtl/pl_reset_sequencer.sv
// ============================================================================
// Module   : pl_reset_sequencer
// Purpose  : Staged PL reset release (interconnect, then peripherals) gated by
//            synchronised pl_resetn0 and clock-wizard locked.
// Options  : PL_RST_SEQ_DEBOUNCE_EN - require DEBOUNCE_CYCLES of low go to abort
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pl_reset_sequencer #(
  parameter int SYNC_STAGES     = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk_in1,
  input  logic             reset,
  input  logic             ext_resetn_in,
  input  logic             dcm_locked,
  output logic             interconnect_aresetn,
  output logic             peripheral_aresetn,
  output logic             peripheral_reset,
  output logic [1:0]       seq_state,
  output logic [CNT_W-1:0] reset_count
);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REL_IC = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int TMR_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(STAGE_GAP - 1);

  generate
    if (SYNC_STAGES < 2 || HOLD_CYCLES < 1 || STAGE_GAP < 1 ||
        DEBOUNCE_CYCLES < 1) begin : g_bad_params
      $error("pl_reset_sequencer: illegal parameter value");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] rstn_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   go;
  logic                   drop;

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      rstn_sync_q <= '0;
      lock_sync_q <= '0;
    end else begin
      rstn_sync_q <= {rstn_sync_q[SYNC_STAGES-2:0], ext_resetn_in};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], dcm_locked};
    end
  end

  assign go = rstn_sync_q[SYNC_STAGES-1] & lock_sync_q[SYNC_STAGES-1];

`ifdef PL_RST_SEQ_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_q;

  // Counts low-go cycles already tolerated; abort fires on the next one.
  always_ff @(posedge clk_in1) begin
    if (reset || go) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q != DB_LAST) begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign drop = ~go & (db_cnt_q == DB_LAST);
`else
  assign drop = ~go;
`endif

  state_t           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic             ic_rstn_q;
  logic             per_rstn_q;
  logic [CNT_W-1:0] count_q;

  // Outputs are written alongside the state so they switch on the same edge.
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state_q    <= ST_ASSERT;
      tmr_q      <= '0;
      ic_rstn_q  <= 1'b0;
      per_rstn_q <= 1'b0;
      count_q    <= '0;
    end else if (drop) begin
      state_q    <= ST_ASSERT;
      tmr_q      <= '0;
      ic_rstn_q  <= 1'b0;
      per_rstn_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (go) begin
            state_q <= ST_HOLD;
            tmr_q   <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (tmr_q == '0) begin
            state_q   <= ST_REL_IC;
            tmr_q     <= GAP_LOAD;
            ic_rstn_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        ST_REL_IC: begin
          if (tmr_q == '0) begin
            state_q    <= ST_RUN;
            per_rstn_q <= 1'b1;
            if (count_q != '1) begin
              count_q <= count_q + 1'b1;
            end
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign interconnect_aresetn = ic_rstn_q;
  assign peripheral_aresetn   = per_rstn_q;
  assign peripheral_reset     = ~per_rstn_q;
  assign seq_state            = state_q;
  assign reset_count          = count_q;

endmodule

`default_nettype wire
